// File: rtl/seg_display_scheduler_if.sv
// seg_display_scheduler_if: bundles the source requests/values and the
// digit handshake toward the display driver.
//   req[2:0]      per-source display request (0 peak, 1 raw volume, 2 frequency)
//   data0..data2  12-bit binary source values
//   display_ready driver accepts digits
//   grant[2:0]    one-hot current owner, 000 when idle
//   digits[15:0]  BCD digits, [15:12] thousands .. [3:0] units
//   digits_valid  digits valid, held until accepted
// master: sources + display driver side; slave: the scheduler.
interface seg_display_scheduler_if;
    logic [2:0]  req;
    logic [11:0] data0;
    logic [11:0] data1;
    logic [11:0] data2;
    logic        display_ready;
    logic [2:0]  grant;
    logic [15:0] digits;
    logic        digits_valid;

    modport master (
        output req, data0, data1, data2, display_ready,
        input  grant, digits, digits_valid
    );

    modport slave (
        input  req, data0, data1, data2, display_ready,
        output grant, digits, digits_valid
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin sharing of the 4-digit display between
// three sources, with a sequential double-dabble binary-to-BCD conversion,
// a valid/ready hand-off to the display driver and a minimum hold time.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seg_display_scheduler_if.slave (req/data in, grant/digits out)
// Parameter HOLD_CYCLES (1..65535): minimum cycles a presented value stays
// granted after the driver accepted it.
// Optional macro SEG_SCHED_BLANK_EN: leading zero nibbles become 4'hF.
module seg_display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input logic                    clk,
    input logic                    rst_n,
    seg_display_scheduler_if.slave bus
);

    localparam int unsigned DATA_W = 12;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SRC_N  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned ITER_W = 4;
    localparam int unsigned HOLD_W = 16;

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(SRC_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        PRESENT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [SRC_N-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BCD_W-1:0]    digits_q, digits_d;
    logic                valid_q, valid_d;

    logic [IDX_W-1:0]    win_idx;
    logic [DATA_W-1:0]   win_data;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;
    logic [BCD_W-1:0]    digits_fmt;

    // Round-robin winner: search starts at the source after the last winner.
    always_comb begin : arbitrate
        win_idx = 2'd0;
        unique case (last_q)
            2'd0: begin
                if (bus.req[1])      win_idx = 2'd1;
                else if (bus.req[2]) win_idx = 2'd2;
                else                 win_idx = 2'd0;
            end
            2'd1: begin
                if (bus.req[2])      win_idx = 2'd2;
                else if (bus.req[0]) win_idx = 2'd0;
                else                 win_idx = 2'd1;
            end
            default: begin
                if (bus.req[0])      win_idx = 2'd0;
                else if (bus.req[1]) win_idx = 2'd1;
                else                 win_idx = 2'd2;
            end
        endcase
    end

    // Winner's value mux.
    always_comb begin : select_data
        win_data = bus.data0;
        unique case (win_idx)
            2'd0:    win_data = bus.data0;
            2'd1:    win_data = bus.data1;
            default: win_data = bus.data2;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next bit.
    always_comb begin : dabble
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
    end

    // Display formatting of the final step's result.
    always_comb begin : format
        digits_fmt = bcd_shift;
`ifdef SEG_SCHED_BLANK_EN
        // Blank leading zeros from the left; units always shown.
        if (bcd_shift[15:12] == 4'd0) begin
            digits_fmt[15:12] = 4'hF;
            if (bcd_shift[11:8] == 4'd0) begin
                digits_fmt[11:8] = 4'hF;
                if (bcd_shift[7:4] == 4'd0) begin
                    digits_fmt[7:4] = 4'hF;
                end
            end
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            grant_q  <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            hold_q   <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            hold_q   <= hold_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin : next_state
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        hold_d   = hold_q;
        digits_d = digits_q;
        valid_d  = valid_q;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|bus.req) begin
                    last_d  = win_idx;
                    grant_d = 3'b001 << win_idx;
                    bin_d   = win_data;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = bcd_shift;
                bin_d  = {bin_q[DATA_W-2:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == ITER_LAST) begin
                    digits_d = digits_fmt;
                    valid_d  = 1'b1;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.display_ready) begin
                    valid_d = 1'b0;
                    hold_d  = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Leave on expiry or when the owner withdraws its request.
                if ((hold_q == '0) || ((bus.req & grant_q) == '0)) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.grant        = grant_q;
    assign bus.digits       = digits_q;
    assign bus.digits_valid = valid_q;

endmodule
